serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first, with a start/busy/done handshake. It succeeds the single-bit combinational full-adder circuit in the architecture lab set. It trades latency for area: one DIGIT-bit ripple slice is reused across WIDTH/DIGIT cycles. It is the arithmetic unit for the multi-cycle datapath exercises that follow.

---
 rtl/arith_pkg.sv | 24 ++
 rtl/serial_addsub_if.sv | 25 ++
 rtl/addsub_slice.sv | 30 +++
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic units: FSM state
// encodings and a ceiling-log2 helper used to size digit counters.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result bundle of the serial adder/subtractor. The requester
// drives start/sub/a/b; the arithmetic unit drives busy/done and results.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple slice: DIGIT full adders chained from
// bit 0 upward. c_msb is the carry into the slice MSB, for overflow.
module addsub_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Ripple the carry through DIGIT full adders, LSB first.
    always_comb begin
        logic [DIGIT:0] c;
        // NOTE: blocking assignments here so each bit sees the carry just
        // produced by the previous iteration within the same evaluation.
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice is reused for
// WIDTH/DIGIT cycles, consuming operands LSB first. Subtraction is
// a + ~b + 1, set up by inverting b and seeding the carry at start.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst,
    serial_addsub_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? clog2(N) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;

    logic [DIGIT-1:0]   slice_s;
    logic               slice_cout;
    logic               slice_c_msb;
    logic               last_digit;

    assign last_digit = (cnt == CNT_W'(N - 1));

    addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .x     (a_sr[DIGIT-1:0]),
        .y     (b_sr[DIGIT-1:0]),
        .cin   (carry),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all flops so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: RUN lasts exactly N cycles, DONE exactly one.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_digit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        bus.busy = (state == ST_RUN);
        bus.done = (state == ST_DONE);
    end

    // Datapath: capture on accepted start, shift one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    // New digit enters at the MSB end; after N shifts the
                    // first digit has reached bit 0.
                    sum_r <= WIDTH'({slice_s, sum_r} >> DIGIT);
                    if (last_digit) begin
                        cout_r <= slice_cout;
                        ovf_r  <= slice_cout ^ slice_c_msb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: six instances covering WIDTH/DIGIT
// combinations, checked against a plain-integer arithmetic model.
module tb_serial_addsub;

    localparam int NI = 6;
    localparam int CW [NI] = '{8, 8, 16, 4, 4, 4};
    localparam int CD [NI] = '{1, 4, 16, 1, 2, 4};

    logic        clk;
    logic        rst;
    logic        start_d [NI];
    logic        sub_d;
    logic [15:0] a_d;
    logic [15:0] b_d;

    logic [15:0] sum_o  [NI];
    logic        busy_o [NI];
    logic        done_o [NI];
    logic        cout_o [NI];
    logic        ovf_o  [NI];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_addsub_if #(.WIDTH(CW[g])) bus ();

        assign bus.start = start_d[g];
        assign bus.sub   = sub_d;
        assign bus.a     = a_d[CW[g]-1:0];
        assign bus.b     = b_d[CW[g]-1:0];
        assign sum_o[g]  = 16'(bus.sum);
        assign busy_o[g] = bus.busy;
        assign done_o[g] = bus.done;
        assign cout_o[g] = bus.cout;
        assign ovf_o[g]  = bus.overflow;

        serial_addsub #(.WIDTH(CW[g]), .DIGIT(CD[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Reference: integer add/subtract, borrow and signed-range overflow.
    function automatic void model(input int w, input int ua, input int ub, input bit s,
                                  output logic [15:0] es, output logic ec, output logic eo);
        int half, full, sa, sb, sr, ur;
        half = 1 << (w - 1);
        full = 1 << w;
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        sr = s ? sa - sb : sa + sb;
        ur = s ? ua - ub : ua + ub;
        es = 16'(ur & (full - 1));
        ec = s ? (ua >= ub) : (ur >= full);
        eo = (sr < -half) || (sr >= half);
    endfunction

    // One operation; entered and left just after a falling edge with the
    // DUT idle, so consecutive calls start on the first IDLE cycle.
    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] es, input logic ec,
                          input logic eo, input bit poke, input string tag);
        int n, busy_cnt, done_cnt, done_at;
        n = CW[i] / CD[i];
        busy_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        a_d = av;
        b_d = bv;
        sub_d = sv;
        start_d[i] = 1'b1;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (busy_o[i]) busy_cnt++;
            if (done_o[i]) begin
                done_cnt++;
                done_at = k;
            end
            if (k == n) begin
                checks += 3;
                if (sum_o[i] !== es) begin
                    errors++;
                    $display("FAIL %s inst%0d sum: got %h exp %h", tag, i, sum_o[i], es);
                end
                if (cout_o[i] !== ec) begin
                    errors++;
                    $display("FAIL %s inst%0d cout: got %b exp %b", tag, i, cout_o[i], ec);
                end
                if (ovf_o[i] !== eo) begin
                    errors++;
                    $display("FAIL %s inst%0d overflow: got %b exp %b", tag, i, ovf_o[i], eo);
                end
            end
            if (k == n + 1) begin
                checks++;
                if (sum_o[i] !== es) begin
                    errors++;
                    $display("FAIL %s inst%0d sum_hold: got %h exp %h", tag, i, sum_o[i], es);
                end
            end
            // Optional extra start pulses land in RUN (k=2) and DONE (k=n).
            start_d[i] = poke && (k == 2 || k == n);
            if (poke && k == 2) begin
                a_d = 16'hFFFF;
                b_d = 16'h1234;
                sub_d = ~sv;
            end
        end
        start_d[i] = 1'b0;
        checks += 3;
        if (busy_cnt != n) begin
            errors++;
            $display("FAIL %s inst%0d busy_cycles: got %0d exp %0d", tag, i, busy_cnt, n);
        end
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s inst%0d done_cycles: got %0d exp 1", tag, i, done_cnt);
        end
        if (done_at != n) begin
            errors++;
            $display("FAIL %s inst%0d done_latency: got %0d exp %0d", tag, i, done_at, n);
        end
    endtask

    task automatic model_op(input int i, input int ua, input int ub, input bit s, input string tag);
        logic [15:0] es;
        logic        ec, eo;
        model(CW[i], ua, ub, s, es, ec, eo);
        run_op(i, 16'(ua), 16'(ub), s, es, ec, eo, 1'b0, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({busy_o[i], done_o[i], cout_o[i], ovf_o[i]} !== 4'b0 || sum_o[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset inst%0d: busy=%b done=%b cout=%b ovf=%b sum=%h exp all 0",
                         i, busy_o[i], done_o[i], cout_o[i], ovf_o[i], sum_o[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, 1'b0, "add_5a_3c");
        run_op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, "add_ff_01");
        run_op(0, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0, 1'b0, 1'b0, "sub_10_20");
        run_op(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, "sub_80_01");
        run_op(1, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, 1'b0, "d4_add_5a_3c");
        run_op(1, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, "d4_sub_80_01");
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "w16_add");
        run_op(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "w16_sub");
    endtask

    task automatic test_start_ignored();
        run_op(0, 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, 1'b1, "start_in_run");
    endtask

    task automatic test_reset_mid_run();
        int busy_cnt, done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        a_d = 16'h5A;
        b_d = 16'h3C;
        sub_d = 1'b0;
        start_d[0] = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            start_d[0] = 1'b0;
            if (k == 3) begin
                checks++;
                if (busy_o[0] !== 1'b0 || sum_o[0] !== 16'h0 || cout_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_run_reset: busy=%b sum=%h cout=%b ovf=%b exp 0/00/0/0",
                             busy_o[0], sum_o[0], cout_o[0], ovf_o[0]);
                end
                rst = 1'b0;
            end
            if (k >= 3) begin
                if (busy_o[0]) busy_cnt++;
                if (done_o[0]) done_cnt++;
            end
            if (k == 2) rst = 1'b1;
        end
        checks++;
        if (busy_cnt != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL mid_run_reset_quiet: busy_cycles=%0d done_cycles=%0d exp 0/0", busy_cnt, done_cnt);
        end
        // Reset and start together: reset wins, nothing is accepted.
        rst = 1'b1;
        start_d[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_d[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_start: busy got %b exp 0", busy_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        model_op(1, 8'hC3, 8'h7E, 1'b0, "b2b_first");
        model_op(1, 8'h11, 8'h22, 1'b1, "b2b_second");
        model_op(0, 8'h7F, 8'h80, 1'b1, "b2b_third");
        model_op(0, 8'h01, 8'h7F, 1'b0, "b2b_fourth");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 30; t++) begin
                int mask;
                mask = (1 << CW[i]) - 1;
                model_op(i, int'($urandom) & mask, int'($urandom) & mask, 1'($urandom), "random");
            end
        end
    endtask

    task automatic test_exhaustive_w4();
        for (int i = 3; i < NI; i++)
            for (int s = 0; s < 2; s++)
                for (int ua = 0; ua < 16; ua++)
                    for (int ub = 0; ub < 16; ub++)
                        model_op(i, ua, ub, 1'(s), "exhaustive_w4");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sub_d = 1'b0;
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < NI; i++) start_d[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_exhaustive_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
